// File: rtl/aes_pkg.sv
// Shared GF(2^8) helpers and FSM state type for the AES InvMixColumns datapath.
// Multipliers are built only from xtime chains, so everything stays 8 bits wide.
package aes_pkg;

  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_col32.sv
// Combinational InvMixColumns of one 32-bit column; row 0 is the most significant byte.
module inv_mix_col32
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col_i;

  assign col_o[31:24] = gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3);
  assign col_o[23:16] = gf_mul09(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3);
  assign col_o[15:8]  = gf_mul0d(a0) ^ gf_mul09(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3);
  assign col_o[7:0]   = gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2) ^ gf_mul0e(a3);

endmodule

// File: rtl/inv_mix_column_seq.sv
// Handshaked multi-cycle AES InvMixColumns, COLS_PER_CYCLE columns per RUN cycle.
// Optional INV_MIX_BYPASS_EN adds a bypass input that passes the state through unchanged.
module inv_mix_column_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
`ifdef INV_MIX_BYPASS_EN
  ,
  input  logic         bypass
`endif
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
    $error("inv_mix_column_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(NUM_COLS - COLS_PER_CYCLE);

  fsm_e state_q, state_d;
  logic [1:0] col_q;
  // Index 3 holds column 0 so the packed view matches the MSB-first byte layout.
  logic [NUM_COLS-1:0][COL_W-1:0] data_q, res_q, res_d;
  logic [127:0] out_q;
  logic byp_q;
  logic accept, last_grp;

  logic [COLS_PER_CYCLE-1:0][1:0]       grp_idx;
  logic [COLS_PER_CYCLE-1:0][COL_W-1:0] col_in, col_mix;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign state_out = out_q;
  assign accept    = in_valid && in_ready;
  assign last_grp  = (col_q == LAST);

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign grp_idx[k] = col_q + 2'(k);
    assign col_in[k]  = data_q[2'd3 - grp_idx[k]];
    inv_mix_col32 u_col (
      .col_i (col_in[k]),
      .col_o (col_mix[k])
    );
  end

  always_comb begin
    res_d = res_q;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      res_d[2'd3 - grp_idx[k]] = byp_q ? col_in[k] : col_mix[k];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_grp)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      data_q  <= '0;
      res_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= state_in;
        col_q  <= '0;
      end
      if (state_q == RUN) begin
        res_q <= res_d;
        col_q <= col_q + STEP;
        // Publish the fully assembled result on the same edge the last group lands.
        if (last_grp) out_q <= res_d;
      end
    end
  end

`ifdef INV_MIX_BYPASS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      byp_q <= 1'b0;
    else if (accept) byp_q <= bypass;
  end
`else
  assign byp_q = 1'b0;
`endif

endmodule
